// File: rtl/io_port_multi.sv
// io_port_multi: memory-mapped GPIO banks with rising-edge irqs
// plus a prescaled 64-bit mtime/mtimecmp timer.
module io_port_multi #(
  parameter int          NGPIO        = 1,
  parameter int          GPIO_W       = 8,
  parameter logic [15:0] PRESCALE_RST = 16'd0
) (
  input  logic                    clk,
  input  logic                    resetb,
  input  logic [7:0]              io_addr,
  input  logic                    io_en,
  input  logic                    io_we,
  input  logic [31:0]             io_data_write,
  output logic [31:0]             io_data_read,
  output logic                    irq_mtimecmp,
  output logic                    irq_gpio,
  inout  wire  [NGPIO*GPIO_W-1:0] io_gpio
);

  localparam int NB = NGPIO * GPIO_W;

  logic [63:0]      mtime;
  logic [63:0]      mtimecmp;
  logic [15:0]      prescale;
  logic [15:0]      pcnt;
  logic [NGPIO-1:0] gpio_ie;
  logic [NB-1:0]    g_out;
  logic [NB-1:0]    g_dir;
  logic [NB-1:0]    sync1;
  logic [NB-1:0]    sync2;
  logic [NB-1:0]    prev;
  logic [NB-1:0]    pend;
  logic [NB-1:0]    w1c;
  logic [7:0]       boff;
  logic [5:0]       bidx;
  logic [1:0]       sub;
  logic             wr;
  logic             rd;
  logic             tick;
  logic             bank_ok;
  logic             gpio_any;
  logic [31:0]      rdata;

  assign wr      = io_en & io_we;
  assign rd      = io_en & ~io_we;
  assign boff    = io_addr - 8'h10;
  assign bidx    = boff[7:2];
  assign sub     = boff[1:0];
  assign bank_ok = (io_addr[7:4] != 4'h0)
                && (int'(bidx) < NGPIO);
  assign tick    = (pcnt == prescale);

  for (genvar i = 0; i < NB; i++) begin : g_pad
    assign io_gpio[i] = g_dir[i] ? g_out[i] : 1'bz;
  end

  always_comb begin
    w1c = '0;
    for (int n = 0; n < NGPIO; n++) begin
      if (wr && bank_ok && sub == 2'd3
          && int'(bidx) == n)
        w1c[n*GPIO_W +: GPIO_W] =
          io_data_write[GPIO_W-1:0];
    end
  end

  always_comb begin
    gpio_any = 1'b0;
    for (int n = 0; n < NGPIO; n++) begin
      gpio_any = gpio_any
        | (gpio_ie[n] & (|pend[n*GPIO_W +: GPIO_W]));
    end
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      io_addr == 8'h00: rdata = mtime[31:0];
      io_addr == 8'h01: rdata = mtime[63:32];
      io_addr == 8'h02: rdata = mtimecmp[31:0];
      io_addr == 8'h03: rdata = mtimecmp[63:32];
      io_addr == 8'h04: rdata[15:0] = prescale;
      io_addr == 8'h05: rdata[NGPIO-1:0] = gpio_ie;
      bank_ok: begin
        for (int n = 0; n < NGPIO; n++) begin
          if (int'(bidx) == n) begin
            case (sub)
              2'd0: rdata[GPIO_W-1:0] =
                      g_out[n*GPIO_W +: GPIO_W];
              2'd1: rdata[GPIO_W-1:0] =
                      g_dir[n*GPIO_W +: GPIO_W];
              2'd2: rdata[GPIO_W-1:0] =
                      sync2[n*GPIO_W +: GPIO_W];
              default: rdata[GPIO_W-1:0] =
                      pend[n*GPIO_W +: GPIO_W];
            endcase
          end
        end
      end
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      mtime        <= '0;
      mtimecmp     <= '1;
      prescale     <= PRESCALE_RST;
      pcnt         <= '0;
      irq_mtimecmp <= 1'b0;
    end else begin
      irq_mtimecmp <= (mtime >= mtimecmp);
      if (wr && io_addr == 8'h04) begin
        prescale <= io_data_write[15:0];
        pcnt     <= '0;
      end else if (tick) begin
        pcnt <= '0;
      end else begin
        pcnt <= pcnt + 16'd1;
      end
      // a software write to mtime suppresses the tick increment
      if (wr && io_addr == 8'h00)
        mtime <= {mtime[63:32], io_data_write};
      else if (wr && io_addr == 8'h01)
        mtime <= {io_data_write, mtime[31:0]};
      else if (tick)
        mtime <= mtime + 64'd1;
      if (wr && io_addr == 8'h02)
        mtimecmp[31:0] <= io_data_write;
      if (wr && io_addr == 8'h03)
        mtimecmp[63:32] <= io_data_write;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      g_out    <= '0;
      g_dir    <= '0;
      sync1    <= '0;
      sync2    <= '0;
      prev     <= '0;
      pend     <= '0;
      gpio_ie  <= '0;
      irq_gpio <= 1'b0;
    end else begin
      sync1    <= io_gpio;
      sync2    <= sync1;
      prev     <= sync2;
      // new edges override a same-cycle clear
      pend     <= (pend & ~w1c) | (sync2 & ~prev);
      irq_gpio <= gpio_any;
      if (wr && io_addr == 8'h05)
        gpio_ie <= io_data_write[NGPIO-1:0];
      for (int n = 0; n < NGPIO; n++) begin
        if (wr && bank_ok && int'(bidx) == n) begin
          if (sub == 2'd0)
            g_out[n*GPIO_W +: GPIO_W] <=
              io_data_write[GPIO_W-1:0];
          if (sub == 2'd1)
            g_dir[n*GPIO_W +: GPIO_W] <=
              io_data_write[GPIO_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb)
      io_data_read <= '0;
    else if (rd)
      io_data_read <= rdata;
  end

endmodule

// File: tb/tb_io_port_multi.sv
// tb_io_port_multi: random bus and pad traffic against a
// reference model of the io_port_multi register behaviour.
module tb_io_port_multi;

  localparam int NG = 3;
  localparam int W  = 4;
  localparam int NB = NG * W;

  logic          clk = 1'b0;
  logic          resetb;
  logic [7:0]    io_addr;
  logic          io_en;
  logic          io_we;
  logic [31:0]   io_data_write;
  logic [31:0]   io_data_read;
  logic          irq_mtimecmp;
  logic          irq_gpio;
  wire  [NB-1:0] pads;
  logic [NB-1:0] tb_oe;
  logic [NB-1:0] drv;

  int total = 0;
  int bad   = 0;

  logic [63:0]   m_mtime;
  logic [63:0]   m_cmp;
  logic [15:0]   m_psc;
  logic [15:0]   m_pcnt;
  logic [NG-1:0] m_ie;
  logic [NB-1:0] m_out;
  logic [NB-1:0] m_dir;
  logic [NB-1:0] m_pend;
  logic [NB-1:0] ph0;
  logic [NB-1:0] ph1;
  logic [NB-1:0] ph2;
  logic [31:0]   m_rd;
  logic          m_irqt;
  logic          m_irqg;

  always #5 clk = ~clk;

  for (genvar i = 0; i < NB; i++) begin : g_drv
    assign pads[i] = tb_oe[i] ? drv[i] : 1'bz;
  end

  io_port_multi #(
    .NGPIO        (NG),
    .GPIO_W       (W),
    .PRESCALE_RST (16'd0)
  ) dut (
    .clk           (clk),
    .resetb        (resetb),
    .io_addr       (io_addr),
    .io_en         (io_en),
    .io_we         (io_we),
    .io_data_write (io_data_write),
    .io_data_read  (io_data_read),
    .irq_mtimecmp  (irq_mtimecmp),
    .irq_gpio      (irq_gpio),
    .io_gpio       (pads)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mtime = '0;
    m_cmp   = '1;
    m_psc   = '0;
    m_pcnt  = '0;
    m_ie    = '0;
    m_out   = '0;
    m_dir   = '0;
    m_pend  = '0;
    ph0     = '0;
    ph1     = '0;
    ph2     = '0;
    m_rd    = '0;
    m_irqt  = 1'b0;
    m_irqg  = 1'b0;
    tb_oe   = '1;
  endtask

  function automatic logic [31:0] mread(input logic [7:0] a);
    logic [31:0]   r;
    logic [NB-1:0] v;
    int            b;
    int            s;
    r = '0;
    case (a)
      8'h00: r = m_mtime[31:0];
      8'h01: r = m_mtime[63:32];
      8'h02: r = m_cmp[31:0];
      8'h03: r = m_cmp[63:32];
      8'h04: r = {16'h0, m_psc};
      8'h05: r = {29'h0, m_ie};
      default: begin
        if (int'(a) >= 16 && int'(a) < 16 + 4*NG) begin
          b = (int'(a) - 16) / 4;
          s = (int'(a) - 16) % 4;
          v = (s == 0) ? m_out :
              (s == 1) ? m_dir :
              (s == 2) ? ph1 : m_pend;
          r[W-1:0] = v[b*W +: W];
        end
      end
    endcase
    return r;
  endfunction

  // advance the model across one clock edge using current inputs
  task automatic step();
    logic [NB-1:0] pad;
    logic [NB-1:0] clr;
    logic [31:0]   d;
    logic [7:0]    a;
    logic          wr;
    logic          tick;
    int            b;
    int            s;
    a   = io_addr;
    d   = io_data_write;
    wr  = io_en & io_we;
    pad = (m_dir & m_out) | (~m_dir & drv);
    if (io_en && !io_we) m_rd = mread(a);
    m_irqt = (m_mtime >= m_cmp);
    m_irqg = 1'b0;
    for (int n = 0; n < NG; n++)
      if (m_ie[n] && m_pend[n*W +: W] != '0) m_irqg = 1'b1;
    b = -1;
    s = 0;
    if (int'(a) >= 16 && int'(a) < 16 + 4*NG) begin
      b = (int'(a) - 16) / 4;
      s = (int'(a) - 16) % 4;
    end
    clr = '0;
    if (wr && b >= 0 && s == 3) clr[b*W +: W] = d[W-1:0];
    m_pend = (m_pend & ~clr) | (ph1 & ~ph2);
    ph2 = ph1;
    ph1 = ph0;
    ph0 = pad;
    tick = (m_pcnt == m_psc);
    if (wr && a == 8'h04)  m_pcnt = '0;
    else if (tick)         m_pcnt = '0;
    else                   m_pcnt = m_pcnt + 16'd1;
    if (wr && a == 8'h00)      m_mtime[31:0]  = d;
    else if (wr && a == 8'h01) m_mtime[63:32] = d;
    else if (tick)             m_mtime = m_mtime + 64'd1;
    if (wr) begin
      case (a)
        8'h02: m_cmp[31:0]  = d;
        8'h03: m_cmp[63:32] = d;
        8'h04: m_psc = d[15:0];
        8'h05: m_ie  = d[NG-1:0];
        default: begin
          if (b >= 0 && s == 0) m_out[b*W +: W] = d[W-1:0];
          if (b >= 0 && s == 1) m_dir[b*W +: W] = d[W-1:0];
        end
      endcase
    end
  endtask

  task automatic cyc(input logic en, input logic we,
                     input logic [7:0] a,
                     input logic [31:0] d);
    io_en         = en;
    io_we         = we;
    io_addr       = a;
    io_data_write = d;
    step();
    @(posedge clk);
    #1;
    tb_oe = ~m_dir;
    #1;
    check("rdata", {32'h0, io_data_read}, {32'h0, m_rd});
    check("irq_t", {63'h0, irq_mtimecmp}, {63'h0, m_irqt});
    check("irq_g", {63'h0, irq_gpio}, {63'h0, m_irqg});
    check("pads", {52'h0, pads & m_dir},
          {52'h0, m_out & m_dir});
  endtask

  task automatic wr_reg(input logic [7:0] a,
                        input logic [31:0] d);
    cyc(1'b1, 1'b1, a, d);
  endtask

  task automatic rd_reg(input logic [7:0] a);
    cyc(1'b1, 1'b0, a, 32'h0);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 8'h00, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d", total);
    $fatal(1);
  end

  initial begin
    int n;
    logic [7:0]  a;
    logic [31:0] d;
    resetb        = 1'b0;
    io_en         = 1'b0;
    io_we         = 1'b0;
    io_addr       = '0;
    io_data_write = '0;
    drv           = 12'h6A9;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdata", {32'h0, io_data_read}, 64'h0);
    check("rst_irqt", {63'h0, irq_mtimecmp}, 64'h0);
    check("rst_irqg", {63'h0, irq_gpio}, 64'h0);
    resetb = 1'b1;

    repeat (3) idle();
    rd_reg(8'h03);
    check("cmp_hi_rst", {32'h0, io_data_read}, 64'hFFFF_FFFF);
    rd_reg(8'h0A);
    check("unmapped", {32'h0, io_data_read}, 64'h0);
    rd_reg(8'h12);
    check("in0_undriven", {32'h0, io_data_read}, 64'h9);
    rd_reg(8'h1A);
    check("in2_undriven", {32'h0, io_data_read}, 64'h6);

    wr_reg(8'h11, 32'h3);
    wr_reg(8'h10, 32'h5);
    check("pad0_drive", {62'h0, pads[1:0]}, 64'h1);
    idle();
    idle();
    rd_reg(8'h12);
    check("in0_mixed", {32'h0, io_data_read}, 64'h9);

    wr_reg(8'h05, 32'h1);
    idle();
    idle();
    wr_reg(8'h13, 32'hF);
    drv[2] = 1'b1;
    repeat (4) idle();
    rd_reg(8'h13);
    check("pend0", {32'h0, io_data_read}, 64'h4);
    check("irq_gpio_on", {63'h0, irq_gpio}, 64'h1);
    drv[2] = 1'b0;
    repeat (3) idle();
    wr_reg(8'h13, 32'hF);
    drv[2] = 1'b1;
    idle();
    idle();
    wr_reg(8'h13, 32'h4);
    idle();
    rd_reg(8'h13);
    check("pend_set_wins", {32'h0, io_data_read}, 64'h4);

    wr_reg(8'h04, 32'h3);
    wr_reg(8'h02, 32'd10);
    wr_reg(8'h03, 32'h0);
    wr_reg(8'h01, 32'h0);
    wr_reg(8'h00, 32'h0);
    n = 0;
    do begin
      idle();
      n++;
    end while (!irq_mtimecmp && n < 100);
    check("mtcmp_lat", {63'h0, n >= 41 && n <= 42}, 64'h1);
    wr_reg(8'h03, 32'h1);
    idle();
    check("mtcmp_drop", {63'h0, irq_mtimecmp}, 64'h0);

    wr_reg(8'h04, 32'h0);
    wr_reg(8'h01, 32'h0);
    wr_reg(8'h00, 32'hFFFF_FFFF);
    idle();
    rd_reg(8'h01);
    check("mtime_carry", {32'h0, io_data_read}, 64'h1);
    wr_reg(8'h00, 32'h1234);
    rd_reg(8'h00);
    check("mtime_wr_wins", {32'h0, io_data_read}, 64'h1234);

    wr_reg(8'h19, 32'hF);
    wr_reg(8'h18, 32'hFFFF_FFFF);
    check("pad2_drive", {60'h0, pads[11:8]}, 64'hF);
    rd_reg(8'h18);
    check("out2_width", {32'h0, io_data_read}, 64'hF);
    rd_reg(8'h1C);
    check("bank_oor", {32'h0, io_data_read}, 64'h0);

    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0:       a = 8'($urandom_range(0, 5));
        1, 2:    a = 8'h10 + 8'($urandom_range(0, 11));
        default: a = 8'($urandom_range(0, 255));
      endcase
      d = $urandom;
      if (a == 8'h04) d = $urandom_range(0, 3);
      if ((a == 8'h00 || a == 8'h02) && $urandom_range(0, 1) == 1)
        d = $urandom_range(0, 40);
      if ((a == 8'h01 || a == 8'h03) && $urandom_range(0, 3) != 0)
        d = 32'h0;
      if ($urandom_range(0, 7) == 0) drv = NB'($urandom);
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          a, d);
    end

    wr_reg(8'h11, 32'hF);
    io_en         = 1'b1;
    io_we         = 1'b1;
    io_addr       = 8'h10;
    io_data_write = 32'hA;
    #3;
    resetb = 1'b0;
    model_reset();
    #1;
    check("mid_rdata", {32'h0, io_data_read}, 64'h0);
    check("mid_irqt", {63'h0, irq_mtimecmp}, 64'h0);
    check("mid_irqg", {63'h0, irq_gpio}, 64'h0);
    @(posedge clk);
    #1;
    resetb = 1'b1;
    rd_reg(8'h11);
    check("mid_dir0", {32'h0, io_data_read}, 64'h0);
    rd_reg(8'h10);
    check("mid_out0", {32'h0, io_data_read}, 64'h0);
    rd_reg(8'h03);
    check("mid_cmp_hi", {32'h0, io_data_read}, 64'hFFFF_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
